// File: rtl/datapath_pkg.sv
// Shared types and widths for the processor datapath: ALU opcode encoding,
// data and address widths, and a name helper for benches and logs.
package datapath_pkg;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned RF_AW  = 4;
  localparam int unsigned D_AW   = 8;

  typedef enum logic [2:0] {
    AluZero  = 3'b000,
    AluAdd   = 3'b001,
    AluSub   = 3'b010,
    AluPassA = 3'b011,
    AluXor   = 3'b100,
    AluOr    = 3'b101,
    AluAnd   = 3'b110,
    AluInc   = 3'b111
  } alu_op_e;

  function automatic string alu_op_to_string(alu_op_e op);
    case (op)
      AluZero:  return "ZERO";
      AluAdd:   return "ADD";
      AluSub:   return "SUB";
      AluPassA: return "PASSA";
      AluXor:   return "XOR";
      AluOr:    return "OR";
      AluAnd:   return "AND";
      AluInc:   return "INC";
      default:  return "UNKNOWN";
    endcase
  endfunction

endpackage

// File: rtl/register_file.sv
// General register file: two combinational read ports, one synchronous write
// port, asynchronous clear. Reads during a write return the pre-edge value.
module register_file #(
  parameter int unsigned DataW = 16,
  parameter int unsigned Depth = 16,
  parameter int unsigned AddrW = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             we_i,
  input  logic [AddrW-1:0] waddr_i,
  input  logic [DataW-1:0] wdata_i,
  input  logic [AddrW-1:0] raddr_a_i,
  input  logic [AddrW-1:0] raddr_b_i,
  output logic [DataW-1:0] rdata_a_o,
  output logic [DataW-1:0] rdata_b_o
);

  localparam int unsigned IdxW = (Depth > 1) ? $clog2(Depth) : 1;

  logic [DataW-1:0] regs_q [Depth];
  logic [DataW-1:0] regs_d [Depth];
  logic [IdxW-1:0]  widx;
  logic [IdxW-1:0]  ridx_a;
  logic [IdxW-1:0]  ridx_b;

  // Smaller register files decode only the low-order address bits.
  assign widx   = waddr_i[IdxW-1:0];
  assign ridx_a = raddr_a_i[IdxW-1:0];
  assign ridx_b = raddr_b_i[IdxW-1:0];

  assign rdata_a_o = regs_q[ridx_a];
  assign rdata_b_o = regs_q[ridx_b];

  always_comb begin
    regs_d = regs_q;
    if (we_i) begin
      regs_d[widx] = wdata_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      regs_q <= '{default: '0};
    end else begin
      regs_q <= regs_d;
    end
  end

endmodule

// File: rtl/datapath_unit.sv
// Execution datapath driven cycle-by-cycle by the control unit: register file,
// combinational ALU, synchronous data memory and write-back select.
module datapath_unit #(
  parameter int unsigned DATA_W     = datapath_pkg::DATA_W,
  parameter int unsigned RF_DEPTH   = 16,
  parameter int unsigned DMEM_DEPTH = 256,
  parameter string       DMEM_INIT  = ""
) (
  input  logic                          Clk,
  input  logic                          ResetN,
  input  logic [datapath_pkg::D_AW-1:0] D_Addr,
  input  logic                          D_Wr,
  input  logic                          RF_s,
  input  logic                          RF_W_en,
  input  logic [datapath_pkg::RF_AW-1:0] RF_W_Addr,
  input  logic [datapath_pkg::RF_AW-1:0] RF_Ra_Addr,
  input  logic [datapath_pkg::RF_AW-1:0] RF_Rb_Addr,
  input  logic [2:0]                    ALU_s0,
  output logic [DATA_W-1:0]             Ra_Data,
  output logic [DATA_W-1:0]             Rb_Data,
  output logic [DATA_W-1:0]             ALU_Q,
  output logic [DATA_W-1:0]             W_Data,
  output logic [DATA_W-1:0]             Mem_Q
);

  import datapath_pkg::*;

  localparam int unsigned DIdxW = (DMEM_DEPTH > 1) ? $clog2(DMEM_DEPTH) : 1;

  logic [DATA_W-1:0] mem [DMEM_DEPTH];
  logic [DIdxW-1:0]  d_idx;
  logic [DATA_W-1:0] mem_rd_d;
  logic [DATA_W-1:0] mem_rd_q;
  logic [DATA_W-1:0] alu_res;

  register_file #(
    .DataW (DATA_W),
    .Depth (RF_DEPTH),
    .AddrW (RF_AW)
  ) u_register_file (
    .clk_i     (Clk),
    .rst_ni    (ResetN),
    .we_i      (RF_W_en),
    .waddr_i   (RF_W_Addr),
    .wdata_i   (W_Data),
    .raddr_a_i (RF_Ra_Addr),
    .raddr_b_i (RF_Rb_Addr),
    .rdata_a_o (Ra_Data),
    .rdata_b_o (Rb_Data)
  );

  always_comb begin
    alu_res = '0;
    unique case (alu_op_e'(ALU_s0))
      AluZero:  alu_res = '0;
      AluAdd:   alu_res = Ra_Data + Rb_Data;
      AluSub:   alu_res = Ra_Data - Rb_Data;
      AluPassA: alu_res = Ra_Data;
      AluXor:   alu_res = Ra_Data ^ Rb_Data;
      AluOr:    alu_res = Ra_Data | Rb_Data;
      AluAnd:   alu_res = Ra_Data & Rb_Data;
      AluInc:   alu_res = Ra_Data + {{(DATA_W-1){1'b0}}, 1'b1};
      default:  alu_res = '0;
    endcase
  end

  assign ALU_Q = alu_res;

  assign d_idx = D_Addr[DIdxW-1:0];

  // Memory array has no reset port (block RAM); reset only masks the write.
  always_ff @(posedge Clk) begin
    if (D_Wr && ResetN) begin
      mem[d_idx] <= Ra_Data;
    end
  end

  always_comb begin
    mem_rd_d = mem[d_idx];
  end

  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      mem_rd_q <= '0;
    end else begin
      mem_rd_q <= mem_rd_d;
    end
  end

  assign Mem_Q  = mem_rd_q;
  assign W_Data = RF_s ? alu_res : mem_rd_q;

endmodule

// File: tb/tb_datapath_unit.sv
// Randomized and directed bench for datapath_unit: a driver pushes expected
// observations from a behavioural model; a negedge monitor pops and compares.
`timescale 1ns/1ps
module tb_datapath_unit;

  typedef struct {
    string       name;
    logic [15:0] ra;
    logic [15:0] rb;
    logic [15:0] alu;
    logic [15:0] wd;
    logic [15:0] mq;
    bit          chk_wd;
    bit          chk_mq;
  } exp_t;

  exp_t sb[$];
  int unsigned total = 0;
  int unsigned bad   = 0;

  logic        Clk = 1'b0;
  logic        ResetN = 1'b0;
  logic [7:0]  d_addr = '0;
  logic        d_wr = 1'b0;
  logic        rf_s = 1'b0;
  logic        rf_we = 1'b0;
  logic [3:0]  rf_wa = '0;
  logic [3:0]  rf_ra = '0;
  logic [3:0]  rf_rb = '0;
  logic [2:0]  alu_op = '0;
  logic [15:0] ra_data, rb_data, alu_q, w_data, mem_q;

  always #5 Clk = ~Clk;

  datapath_unit dut (
    .Clk        (Clk),
    .ResetN     (ResetN),
    .D_Addr     (d_addr),
    .D_Wr       (d_wr),
    .RF_s       (rf_s),
    .RF_W_en    (rf_we),
    .RF_W_Addr  (rf_wa),
    .RF_Ra_Addr (rf_ra),
    .RF_Rb_Addr (rf_rb),
    .ALU_s0     (alu_op),
    .Ra_Data    (ra_data),
    .Rb_Data    (rb_data),
    .ALU_Q      (alu_q),
    .W_Data     (w_data),
    .Mem_Q      (mem_q)
  );

  // Reference model state
  logic [15:0] m_rf [16];
  logic [15:0] m_mem [256];
  bit          m_known [256];
  logic [15:0] m_mq;
  bit          m_mq_known;

  function automatic logic [15:0] alu_ref(input logic [2:0] op, input logic [15:0] a,
                                          input logic [15:0] b);
    case (op)
      3'd0:    return 16'h0000;
      3'd1:    return a + b;
      3'd2:    return a - b;
      3'd3:    return a;
      3'd4:    return a ^ b;
      3'd5:    return a | b;
      3'd6:    return a & b;
      default: return a + 16'd1;
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_rf[i] = 16'h0000;
    m_mq       = 16'h0000;
    m_mq_known = 1'b1;
  endtask

  task automatic chk(input string nm, input string field, input logic [15:0] act,
                     input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s.%s got=%h want=%h @%0t", nm, field, act, exp, $time);
    end
  endtask

  // Called at posedge+1: drive one cycle, queue its expectation, advance the model.
  task automatic step(input string nm, input logic [7:0] da, input logic dw, input logic rs,
                      input logic we, input logic [3:0] wa, input logic [3:0] ra,
                      input logic [3:0] rb, input logic [2:0] op, input bit late_rst = 1'b0);
    exp_t        e;
    logic [15:0] a, b, w;
    d_addr = da; d_wr = dw; rf_s = rs; rf_we = we; rf_wa = wa;
    rf_ra = ra; rf_rb = rb; alu_op = op;
    if (!ResetN) model_reset();
    a = m_rf[ra];
    b = m_rf[rb];
    w = rs ? alu_ref(op, a, b) : m_mq;
    e.name = nm; e.ra = a; e.rb = b; e.alu = alu_ref(op, a, b); e.wd = w; e.mq = m_mq;
    e.chk_wd = rs || m_mq_known;
    e.chk_mq = m_mq_known;
    sb.push_back(e);
    if (late_rst) begin
      #8.999;
      ResetN = 1'b0;
    end
    @(posedge Clk);
    if (!ResetN) begin
      model_reset();
    end else begin
      m_mq       = m_mem[da];
      m_mq_known = m_known[da];
      if (dw) begin
        m_mem[da]   = a;
        m_known[da] = 1'b1;
      end
      if (we) m_rf[wa] = w;
    end
    #1;
  endtask

  always @(negedge Clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      chk(e.name, "Ra_Data", ra_data, e.ra);
      chk(e.name, "Rb_Data", rb_data, e.rb);
      chk(e.name, "ALU_Q", alu_q, e.alu);
      if (e.chk_wd) chk(e.name, "W_Data", w_data, e.wd);
      if (e.chk_mq) chk(e.name, "Mem_Q", mem_q, e.mq);
    end
  end

  initial begin
    #100us;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    logic       rs, we;
    logic [2:0] op;
    model_reset();
    for (int i = 0; i < 256; i++) m_known[i] = 1'b0;
    m_mq_known = 1'b1;
    repeat (2) @(posedge Clk);
    #1;
    step("rst_hold", 8'h00, 1'b1, 1'b1, 1'b1, 4'd3, 4'd1, 4'd2, 3'd3);
    ResetN = 1'b1;

    step("pre_r5", 8'h00, 1'b0, 1'b1, 1'b1, 4'd5, 4'd0, 4'd0, 3'd7);
    step("pre_r6", 8'h00, 1'b0, 1'b1, 1'b1, 4'd6, 4'd5, 4'd0, 3'd7);
    ResetN = 1'b0;
    step("rst_mid", 8'h00, 1'b0, 1'b1, 1'b0, 4'd0, 4'd5, 4'd6, 3'd3);
    ResetN = 1'b1;
    step("rst_r5", 8'h00, 1'b0, 1'b1, 1'b0, 4'd0, 4'd5, 4'd6, 3'd3);

    step("inc_r1", 8'h00, 1'b0, 1'b1, 1'b1, 4'd1, 4'd0, 4'd0, 3'd7);
    step("inc_r2", 8'h00, 1'b0, 1'b1, 1'b1, 4'd2, 4'd1, 4'd0, 3'd7);
    step("add_r3", 8'h00, 1'b0, 1'b1, 1'b1, 4'd3, 4'd1, 4'd2, 3'd1);

    step("st_2a", 8'h2A, 1'b1, 1'b1, 1'b0, 4'd0, 4'd3, 4'd0, 3'd3);
    step("ld_addr", 8'h2A, 1'b0, 1'b1, 1'b0, 4'd0, 4'd3, 4'd0, 3'd3);
    step("ld_wb", 8'h2A, 1'b0, 1'b0, 1'b1, 4'd9, 4'd3, 4'd0, 3'd3);
    step("rd_r9", 8'h00, 1'b0, 1'b1, 1'b0, 4'd0, 4'd9, 4'd3, 3'd2);

    step("sub_r4", 8'h00, 1'b0, 1'b1, 1'b1, 4'd4, 4'd0, 4'd1, 3'd2);
    step("inc_wrap", 8'h00, 1'b0, 1'b1, 1'b0, 4'd0, 4'd4, 4'd3, 3'd7);
    step("xor", 8'h00, 1'b0, 1'b1, 1'b0, 4'd0, 4'd4, 4'd3, 3'd4);
    step("or", 8'h00, 1'b0, 1'b1, 1'b0, 4'd0, 4'd4, 4'd3, 3'd5);
    step("and", 8'h00, 1'b0, 1'b1, 1'b0, 4'd0, 4'd4, 4'd3, 3'd6);
    step("zero", 8'h00, 1'b0, 1'b1, 1'b0, 4'd0, 4'd4, 4'd3, 3'd0);

    step("rdw_wr", 8'h00, 1'b0, 1'b1, 1'b1, 4'd2, 4'd2, 4'd0, 3'd7);
    step("rdw_rd", 8'h00, 1'b0, 1'b1, 1'b0, 4'd0, 4'd2, 4'd0, 3'd3);
    step("mem_rdw", 8'h2A, 1'b1, 1'b1, 1'b0, 4'd0, 4'd4, 4'd0, 3'd3);
    step("mem_old", 8'h2A, 1'b0, 1'b1, 1'b0, 4'd0, 4'd4, 4'd0, 3'd3);
    step("mem_new", 8'h2A, 1'b0, 1'b1, 1'b0, 4'd0, 4'd4, 4'd0, 3'd3);

    step("rst_wr", 8'h2A, 1'b1, 1'b1, 1'b1, 4'd7, 4'd3, 4'd4, 3'd3, 1'b1);
    ResetN = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step("rst_clr", 8'h00, 1'b0, 1'b1, 1'b0, 4'd0, 4'(i), 4'(i + 8), 3'd3);
    end
    step("rst_ld0", 8'h2A, 1'b0, 1'b1, 1'b0, 4'd0, 4'd0, 4'd0, 3'd3);
    step("rst_ld1", 8'h2A, 1'b0, 1'b1, 1'b0, 4'd0, 4'd0, 4'd0, 3'd3);

    for (int i = 1; i < 16; i++) begin
      step("fill_rf", 8'h00, 1'b0, 1'b1, 1'b1, 4'(i), 4'(i - 1), 4'd0, 3'd7);
    end
    for (int i = 0; i < 256; i++) begin
      step("fill_mem", 8'(i), 1'b1, 1'b1, 1'b0, 4'd0, 4'(i), 4'(i + 3), 3'd1);
    end

    for (int i = 0; i < 300; i++) begin
      rs = 1'($urandom_range(1));
      we = 1'($urandom_range(1));
      op = 3'($urandom_range(7));
      if (!m_mq_known) rs = 1'b1;
      step("rand", 8'($urandom_range(255)), ($urandom_range(3) == 0), rs, we,
           4'($urandom_range(15)), 4'($urandom_range(15)), 4'($urandom_range(15)), op);
    end

    repeat (2) @(negedge Clk);
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain got=%0d want=0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
